// File: rtl/mult_pipe_param.sv
// Pipelined shift-and-add multiplier with one partial product per stage.
// Stage 0 registers the operands and mode. Stage k (k = 1..WIDTH) adds the
// multiplicand, shifted by k-1, when multiplier bit k-1 is set. Stage WIDTH
// subtracts instead of adding for signed operands, because the multiplier MSB
// has weight -2^(WIDTH-1).
// Handshake: the whole pipeline advances together when adv = ~out_valid | out_ready,
// and in_ready = adv. An input transfer happens on an edge where
// in_valid & in_ready. An output transfer happens on an edge where
// out_valid & out_ready. While adv=0 every register, valid bits included, holds.
module mult_pipe_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);

  localparam int PW = 2 * WIDTH;

  logic             adv;

  // Stage 0: the raw operands and mode.
  logic             s0_v_q, s0_v_d;
  logic             s0_sg_q, s0_sg_d;
  logic [WIDTH-1:0] s0_a_q, s0_a_d;
  logic [WIDTH-1:0] s0_b_q, s0_b_d;

  // Stages 1..WIDTH: valid, partial sum, shifted multiplicand, multiplier and mode.
  logic             v_q   [1:WIDTH];
  logic             v_d   [1:WIDTH];
  logic [PW-1:0]    sum_q [1:WIDTH];
  logic [PW-1:0]    sum_d [1:WIDTH];
  logic [PW-1:0]    mc_q  [1:WIDTH];
  logic [PW-1:0]    mc_d  [1:WIDTH];
  logic [WIDTH-1:0] mp_q  [1:WIDTH];
  logic [WIDTH-1:0] mp_d  [1:WIDTH];
  logic             sg_q  [1:WIDTH];
  logic             sg_d  [1:WIDTH];

  logic [PW-1:0]    ext;
  logic [PW-1:0]    term;

  assign adv       = ~v_q[WIDTH] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[WIDTH];
  assign out_prod  = sum_q[WIDTH];

  // Stage 0 next state: capture the operands. The valid bit is set only when
  // the pair is actually accepted.
  always_comb begin
    s0_v_d  = in_valid & adv;
    s0_sg_d = in_signed;
    s0_a_d  = in_a;
    s0_b_d  = in_b;
  end

  // Partial-product stages: extend the multiplicand, then add (or subtract at
  // the MSB stage) one shifted copy per stage.
  always_comb begin
    ext  = s0_sg_q ? {{WIDTH{s0_a_q[WIDTH-1]}}, s0_a_q} : {{WIDTH{1'b0}}, s0_a_q};
    term = '0;

    v_d[1]   = s0_v_q;
    sum_d[1] = s0_b_q[0] ? ext : '0;
    mc_d[1]  = ext << 1;
    mp_d[1]  = s0_b_q;
    sg_d[1]  = s0_sg_q;

    for (int k = 2; k <= WIDTH; k++) begin
      term     = mp_q[k-1][k-1] ? mc_q[k-1] : '0;
      v_d[k]   = v_q[k-1];
      mp_d[k]  = mp_q[k-1];
      sg_d[k]  = sg_q[k-1];
      mc_d[k]  = mc_q[k-1] << 1;
      if ((k == WIDTH) && sg_q[k-1]) begin
        sum_d[k] = sum_q[k-1] - term;
      end else begin
        sum_d[k] = sum_q[k-1] + term;
      end
    end
  end

  // Pipeline registers: reset clears everything, otherwise all stages move in lockstep on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v_q  <= 1'b0;
      s0_sg_q <= 1'b0;
      s0_a_q  <= '0;
      s0_b_q  <= '0;
      for (int k = 1; k <= WIDTH; k++) begin
        v_q[k]   <= 1'b0;
        sum_q[k] <= '0;
        mc_q[k]  <= '0;
        mp_q[k]  <= '0;
        sg_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      s0_v_q  <= s0_v_d;
      s0_sg_q <= s0_sg_d;
      s0_a_q  <= s0_a_d;
      s0_b_q  <= s0_b_d;
      for (int k = 1; k <= WIDTH; k++) begin
        v_q[k]   <= v_d[k];
        sum_q[k] <= sum_d[k];
        mc_q[k]  <= mc_d[k];
        mp_q[k]  <= mp_d[k];
        sg_q[k]  <= sg_d[k];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed bench for mult_pipe_param. There are two instances: WIDTH=8 for the
// directed cases and WIDTH=4 for a full operand sweep in both modes.
module tb_mult_pipe_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_prod;

  // WIDTH=4 instance signals
  logic        w4_in_valid = 1'b0, w4_in_signed = 1'b0, w4_out_ready = 1'b1;
  logic [3:0]  w4_in_a = '0, w4_in_b = '0;
  logic        w4_in_ready, w4_out_valid;
  logic [7:0]  w4_out_prod;

  mult_pipe_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
  );

  mult_pipe_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .in_signed(w4_in_signed), .in_a(w4_in_a), .in_b(w4_in_b),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready), .out_prod(w4_out_prod)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp4_q[$];
  int run_len = 0;
  int max_run = 0;
  int seen_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // An output transfer happens on the next rising edge when out_valid & out_ready is seen here.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (!rst && out_valid && out_ready) begin
        seen_cnt++;
        if (exp_q.size() == 0) chk("w8_unexpected_item", 32'd1, 32'd0);
        else chk("w8_prod", {16'h0, out_prod}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && w4_out_valid && w4_out_ready) begin
        if (exp4_q.size() == 0) chk("w4_unexpected_item", 32'd1, 32'd0);
        else chk("w4_prod", {24'h0, w4_out_prod}, {24'h0, exp4_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic put(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int n;
    n = 0;
    in_valid = 1'b1; in_signed = s; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("put_timeout", 32'd1, 32'd0);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [15:0] held;
    int sa, sb, p;
    logic [7:0] e4;

    // Reset state
    rst = 1'b1;
    cycles(3);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_prod", {16'h0, out_prod}, 32'd0);
    rst = 1'b0;
    cycles(1);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_w4_out_valid", {31'h0, w4_out_valid}, 32'd0);

    // T1: 255*255 unsigned. The product appears after the 9th edge, counting the acceptance edge.
    in_valid = 1'b1; in_signed = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
    exp_q.push_back(16'hFE01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t1_latency", lat, 32'd9);
    chk("t1_prod_direct", {16'h0, out_prod}, 32'h0000FE01);
    drain("t1_drain");

    // T2: signed corner cases plus unsigned counterparts of the same bit patterns.
    put(1'b1, 8'h80, 8'h80, 16'h4000);   // -128 * -128
    put(1'b1, 8'hFF, 8'h7F, 16'hFF81);   // -1 * 127
    put(1'b1, 8'h7F, 8'h80, 16'hC080);   // 127 * -128
    put(1'b0, 8'h80, 8'h80, 16'h4000);   // 128 * 128
    put(1'b0, 8'hFF, 8'h7F, 16'h7E81);   // 255 * 127
    put(1'b1, 8'hFF, 8'hFF, 16'h0001);   // -1 * -1
    put(1'b0, 8'h7F, 8'h80, 16'h3F80);   // 127 * 128
    drain("t2_drain");

    // T3: back-to-back stream i*3 with alternating mode.
    cycles(2);
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      put(i[0], i[7:0], 8'd3, i[15:0] * 16'd3);
    end
    drain("t3_drain");
    chk("t3_consecutive_valid", max_run, 32'd16);

    // T4: stall a full pipeline for 3 cycles, then release it.
    seen_cnt = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          put(1'b0, 8'(i + 10), 8'(i + 3), 16'(((i + 10) * (i + 3))));
        end
      end
      begin
        cycles(12);
        out_ready = 1'b0;
        #1;
        chk("t4_in_ready_low", {31'h0, in_ready}, 32'd0);
        chk("t4_out_valid_held", {31'h0, out_valid}, 32'd1);
        held = out_prod;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          chk("t4_prod_stable", {16'h0, out_prod}, {16'h0, held});
          chk("t4_in_ready_stall", {31'h0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain("t4_drain");
    chk("t4_delivered", seen_cnt, 32'd20);

    // T5: reset with 5 items in flight; nothing stale may come out afterwards.
    cycles(2);
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 8'(i + 1), 8'hFE, 16'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t5_out_valid", {31'h0, out_valid}, 32'd0);
    chk("t5_out_prod", {16'h0, out_prod}, 32'd0);
    chk("t5_in_ready", {31'h0, in_ready}, 32'd1);
    seen_cnt = 0;
    cycles(15);
    chk("t5_no_stale", seen_cnt, 32'd0);
    put(1'b1, 8'hF6, 8'h05, 16'hFFCE);   // -10 * 5 = -50
    drain("t5_after_drain");

    // T6: WIDTH=4 sweep over all pairs in both modes, streamed back to back.
    w4_out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sa = (m == 1 && a >= 8) ? a - 16 : a;
          sb = (m == 1 && b >= 8) ? b - 16 : b;
          p  = sa * sb;
          e4 = p[7:0];
          w4_in_valid = 1'b1; w4_in_signed = m[0]; w4_in_a = a[3:0]; w4_in_b = b[3:0];
          exp4_q.push_back(e4);
          @(posedge clk); #1;
        end
      end
    end
    w4_in_valid = 1'b0;
    lat = 0;
    while (exp4_q.size() != 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_drain", exp4_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
